// File: rtl/seg7_scan_driver_pkg.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver_pkg
//   Shared constants for the 8-digit common-anode 7-segment scan driver.
//   - SEG_OFF / AN_OFF : all-dark patterns (everything is active-low)
//   - HEX7_TABLE       : 16 hex glyphs, bits {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
package seg7_scan_driver_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Index n holds the glyph for hex digit n; entry 15 is written first.
  localparam logic [15:0][6:0] HEX7_TABLE = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// -----------------------------------------------------------------------------
// seg7_hex_decoder
//   Combinational nibble-to-glyph decoder for a common-anode display.
//   Ports:
//     i_nibble  in  4  hex value to show
//     i_dp      in  1  1 = light the decimal point
//     o_seg     out 8  active-low segments {dp,g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg7_hex_decoder
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  output logic [7:0] o_seg
);

  assign o_seg = {~i_dp, HEX7_TABLE[i_nibble]};

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//   Time-multiplexes a 32-bit value (8 hex digits), per-digit decimal points
//   and per-digit blink enables onto one 8-digit common-anode display.
//   Input data is captured into shadow registers only at frame boundaries so a
//   mid-frame change never shows half old / half new digits.
//   Parameters:
//     SCAN_W   each digit slot lasts 2**SCAN_W clk cycles
//     BLANK    cycles at the start of each slot with anodes off (< 2**SCAN_W)
//     BLINK_W  blink counter width; blink phase is the counter MSB
//   Ports:
//     clk         in   1   rising-edge clock
//     rst         in   1   synchronous active-high reset
//     EN          in   1   1 = shadows may load at the frame boundary
//     Disp_num    in   32  digit i shows Disp_num[4i+3:4i], digit 0 rightmost
//     point_in    in   8   bit i lights the decimal point of digit i
//     LE_in       in   8   bit i makes digit i blink
//     AN          out  8   anode selects, active-low, at most one low
//     SEGMENT     out  8   active-low segments {dp,g,f,e,d,c,b,a}
//     frame_tick  out  1   high in the cycle the shadows load
// -----------------------------------------------------------------------------
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int SCAN_W  = 17,
  parameter int BLANK   = 64,
  parameter int BLINK_W = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EN,
  input  logic [31:0] Disp_num,
  input  logic [7:0]  point_in,
  input  logic [7:0]  LE_in,
  output logic [7:0]  AN,
  output logic [7:0]  SEGMENT,
  output logic        frame_tick
);

  localparam logic [SCAN_W-1:0] SCAN_MAX = '1;
  localparam logic [SCAN_W-1:0] BLANK_C  = SCAN_W'(BLANK);

  logic [SCAN_W-1:0]  r_scan_cnt;
  logic [2:0]         r_digit;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic [31:0]        r_num_sh;
  logic [7:0]         r_pt_sh;
  logic [7:0]         r_le_sh;
  logic               r_init_pend;
  logic [7:0]         r_an;
  logic [7:0]         r_seg;

  logic               w_frame_end;
  logic               w_load;
  logic [3:0]         w_nibble;
  logic               w_blink_off;
  logic               w_blank;
  logic [7:0]         w_glyph;

  // Stage 0: scan position, frame boundary and shadow load decision
  assign w_frame_end = (r_scan_cnt == SCAN_MAX) && (r_digit == 3'd7);
  // init_pend lets the very first EN=1 cycle after reset load immediately
  // instead of showing blanks for a whole frame.
  assign w_load      = (w_frame_end || r_init_pend) && EN;
  // Gated by rst so no pulse is reported while the block is held in reset.
  assign frame_tick  = w_load && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt  <= '0;
      r_digit     <= '0;
      r_blink_cnt <= '0;
      r_init_pend <= 1'b1;
      r_num_sh    <= '0;
      r_pt_sh     <= '0;
      r_le_sh     <= '0;
    end else begin
      r_scan_cnt  <= r_scan_cnt + 1'b1;
      r_blink_cnt <= r_blink_cnt + 1'b1;
      if (r_scan_cnt == SCAN_MAX) begin
        r_digit <= r_digit + 3'd1;
      end
      // Loading on the same edge the digit wraps to 0 means the new data
      // appears starting with digit 0 of the next frame.
      if (w_load) begin
        r_num_sh    <= Disp_num;
        r_pt_sh     <= point_in;
        r_le_sh     <= LE_in;
        r_init_pend <= 1'b0;
      end
    end
  end

  // Stage 1: decode the active digit from the shadows
  assign w_nibble    = r_num_sh[{r_digit, 2'b00} +: 4];
  assign w_blink_off = r_blink_cnt[BLINK_W-1] & r_le_sh[r_digit];
  // Anodes stay dark for the first BLANK cycles of a slot so the previous
  // digit's segments have settled before the next anode turns on.
  assign w_blank     = (r_scan_cnt < BLANK_C);

  seg7_hex_decoder u_hex (
    .i_nibble (w_nibble),
    .i_dp     (r_pt_sh[r_digit]),
    .o_seg    (w_glyph)
  );

  // Stage 2: registered anode and segment drive
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
    end else if (w_blank) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
    end else begin
      r_an  <= ~(8'b1 << r_digit);
      r_seg <= w_blink_off ? SEG_OFF : w_glyph;
    end
  end

  assign AN      = r_an;
  assign SEGMENT = r_seg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        EN;
  logic [31:0] Disp_num;
  logic [7:0]  point_in;
  logic [7:0]  LE_in;
  logic [7:0]  AN;
  logic [7:0]  SEGMENT;
  logic        frame_tick;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .SCAN_W  (2),
    .BLANK   (1),
    .BLINK_W (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .EN         (EN),
    .Disp_num   (Disp_num),
    .point_in   (point_in),
    .LE_in      (LE_in),
    .AN         (AN),
    .SEGMENT    (SEGMENT),
    .frame_tick (frame_tick)
  );

  typedef struct {
    logic [7:0] an;
    logic [7:0] seg;
    logic       tick;
    string      tag;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   cyc_no = 0;

  // Hand-decoded glyph rows, packed {digit7,...,digit0}
  localparam logic [63:0] S_A = 64'hF9A4_B099_9282_F880; // 12345678
  localparam logic [63:0] S_B = 64'hC0C0_C0C0_C0C0_C040; // 0, dp on digit 0
  localparam logic [63:0] S_F = 64'h8E8E_8E8E_8E8E_8E8E; // FFFFFFFF
  localparam logic [63:0] S_Z = 64'hC0C0_C0C0_C0C0_C0C0; // 00000000
  localparam logic [63:0] S_G = 64'h0090_8883_C6A1_868E; // 89ABCDEF, dp digit 7

  task automatic chk8(input string nm, input exp_t e, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s %s cyc %0d: got %h required %h", e.tag, nm, e.cyc, act, req);
    end
  endtask

  // Monitor: one expected entry per cycle, sampled 2 ns before the rising edge
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        m_e = sb.pop_front();
        chk8("AN", m_e, AN, m_e.an);
        chk8("SEGMENT", m_e, SEGMENT, m_e.seg);
        chk8("frame_tick", m_e, {7'd0, frame_tick}, {7'd0, m_e.tick});
      end
    end
  end

  task automatic next_cycle();
    @(negedge clk);
    cyc_no++;
  endtask

  task automatic expect_out(input logic [7:0] an, input logic [7:0] seg, input logic tick, input string tag);
    exp_t e;
    e.an   = an;
    e.seg  = seg;
    e.tick = tick;
    e.tag  = tag;
    e.cyc  = cyc_no;
    sb.push_back(e);
  endtask

  // One 32-cycle output frame. Inputs switch to the next values at cycle
  // chg_c; rst is raised at cycle rst_c (frame aborted there).
  task automatic run_frame(input logic [63:0] segs, input logic [7:0] blk, input logic tick_exp,
                           input int chg_c, input logic [31:0] nn, input logic [7:0] np,
                           input logic [7:0] nl, input logic ne, input int rst_c, input string tag);
    for (int c = 0; c < 32; c++) begin
      int d;
      int ph;
      logic [7:0] ea;
      logic [7:0] es;
      logic       et;
      next_cycle();
      if (c == chg_c) begin
        Disp_num = nn;
        point_in = np;
        LE_in    = nl;
        EN       = ne;
      end
      if (c == rst_c) rst = 1'b1;
      d  = c / 4;
      ph = c % 4;
      ea = (ph == 0) ? 8'hFF : ~(8'(8'h01 << d));
      es = (ph == 0) ? 8'hFF : (blk[d] ? 8'hFF : segs[d*8 +: 8]);
      et = (c == 30) ? tick_exp : 1'b0;
      expect_out(ea, es, et, tag);
      if (c == rst_c) break;
    end
  endtask

  initial begin
    rst      = 1'b1;
    EN       = 1'b1;
    Disp_num = 32'h1234_5678;
    point_in = 8'h00;
    LE_in    = 8'h00;

    for (int i = 0; i < 3; i++) begin
      next_cycle();
      expect_out(8'hFF, 8'hFF, 1'b0, "reset");
    end
    next_cycle();
    rst = 1'b0;
    expect_out(8'hFF, 8'hFF, 1'b1, "release");

    run_frame(S_A, 8'h00, 1'b1, 13, 32'h0000_0000, 8'h01, 8'h00, 1'b1, -1, "scan");
    run_frame(S_B, 8'h00, 1'b1, 13, 32'hFFFF_FFFF, 8'h00, 8'h00, 1'b1, -1, "dp");
    run_frame(S_F, 8'h00, 1'b0, 13, 32'h1234_5678, 8'h00, 8'h00, 1'b0, -1, "allF");
    run_frame(S_F, 8'h00, 1'b1, 13, 32'h1234_5678, 8'h00, 8'h80, 1'b1, -1, "frozen");
    run_frame(S_A, 8'h80, 1'b1, 13, 32'h1234_5678, 8'h00, 8'h81, 1'b1, -1, "blink80");
    run_frame(S_A, 8'h80, 1'b1, 13, 32'h0000_0000, 8'h00, 8'h00, 1'b1, -1, "blink81");
    run_frame(S_Z, 8'h00, 1'b1, 13, 32'h89AB_CDEF, 8'h80, 8'h00, 1'b1, 21, "zero");

    next_cycle();
    expect_out(8'hFF, 8'hFF, 1'b0, "midrst");
    next_cycle();
    rst = 1'b0;
    expect_out(8'hFF, 8'hFF, 1'b1, "rerelease");
    run_frame(S_G, 8'h00, 1'b1, -1, 32'h0, 8'h0, 8'h0, 1'b1, -1, "restart");

    @(negedge clk);
    #5;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries left required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
